// File: rtl/machine_mode_types_1_7_pkg.sv
// machine_mode_types_1_7_pkg: shared machine-mode types and constants for the privilege unit.
package machine_mode_types_1_7_pkg;
    typedef logic [63:0] mtime_t;
    localparam mtime_t MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/priv_1_7_int_sync.sv
// priv_1_7_int_sync: SYNC_STAGES-deep flop chain bringing an asynchronous level into CLK.
module priv_1_7_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic nRST,
    input  logic async_i,
    output logic sync_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
    assign sync_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/priv_1_7_int_source.sv
// priv_1_7_int_source: machine timer, software and external interrupt sources.
// Define PRIV_EXT_INT_EDGE_EN for an edge-latched external interrupt; level mode otherwise.
module priv_1_7_int_source
    import machine_mode_types_1_7_pkg::*;
#(
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ext_int_in,
    input  logic        ext_int_ack,
    input  logic        soft_int_set,
    input  logic        soft_int_clr,
    input  logic        mtimecmp_wen,
    input  logic        mtimecmp_hi,
    input  logic [31:0] mtimecmp_wdata,
    input  logic        clear_timer_int,
    output logic        timer_int,
    output logic        soft_int,
    output logic        ext_int,
    output mtime_t      mtime,
    output mtime_t      mtimecmp
);
    logic [15:0] cnt_q, cnt_d;
    mtime_t      mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic        timer_q, timer_d, soft_q, soft_d, tick, s_out;
    assign tick = cnt_q == 16'(PRESCALE - 1);
    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = !mtimecmp_wen ? mtimecmp_q :
                     mtimecmp_hi   ? {mtimecmp_wdata, mtimecmp_q[31:0]} :
                                     {mtimecmp_q[63:32], mtimecmp_wdata};
        // a write or clear beats a live compare so software can always drop the line
        timer_d    = (mtimecmp_wen | clear_timer_int) ? 1'b0 : (mtime_q >= mtimecmp_q) | timer_q;
        soft_d     = soft_int_set | (soft_q & ~soft_int_clr);
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            timer_q    <= 1'b0;
            soft_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            timer_q    <= timer_d;
            soft_q     <= soft_d;
        end
    end
    priv_1_7_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK    (CLK),
        .nRST   (nRST),
        .async_i(ext_int_in),
        .sync_o (s_out)
    );
`ifdef PRIV_EXT_INT_EDGE_EN
    logic s_out_d_q, ext_q, ext_d;
    assign ext_d = (s_out & ~s_out_d_q) | (ext_q & ~ext_int_ack);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s_out_d_q <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            s_out_d_q <= s_out;
            ext_q     <= ext_d;
        end
    end
    assign ext_int = ext_q;
`else
    logic unused_ack;
    assign unused_ack = ext_int_ack;
    assign ext_int    = s_out;
`endif
    assign timer_int = timer_q;
    assign soft_int  = soft_q;
    assign mtime     = mtime_q;
    assign mtimecmp  = mtimecmp_q;
endmodule

// File: tb/tb_priv_1_7_int_source.sv
// tb_priv_1_7_int_source: directed plus random checks of priv_1_7_int_source against a reference model.
module tb_priv_1_7_int_source;
    localparam int S = 2;
    logic        clk = 0, nRST = 0;
    logic        ext_in = 0, ack = 0, sset = 0, sclr = 0, wen = 0, hi = 0, clr = 0;
    logic [31:0] wdata = 0;
    logic        t1, s1, e1, t4, s4, e4;
    logic [63:0] mt1, mc1, mt4, mc4;
    int          checks = 0, errors = 0;

    logic [63:0] m_mtime, m_cmp;
    logic        m_timer, m_soft, m_ext;
    logic        hist[$];
    int          cyc;

    priv_1_7_int_source #(.PRESCALE(1), .SYNC_STAGES(S)) u1 (
        .CLK(clk), .nRST(nRST), .ext_int_in(ext_in), .ext_int_ack(ack),
        .soft_int_set(sset), .soft_int_clr(sclr), .mtimecmp_wen(wen), .mtimecmp_hi(hi),
        .mtimecmp_wdata(wdata), .clear_timer_int(clr), .timer_int(t1), .soft_int(s1),
        .ext_int(e1), .mtime(mt1), .mtimecmp(mc1));
    priv_1_7_int_source #(.PRESCALE(4), .SYNC_STAGES(S)) u4 (
        .CLK(clk), .nRST(nRST), .ext_int_in(ext_in), .ext_int_ack(ack),
        .soft_int_set(sset), .soft_int_clr(sclr), .mtimecmp_wen(wen), .mtimecmp_hi(hi),
        .mtimecmp_wdata(wdata), .clear_timer_int(clr), .timer_int(t4), .soft_int(s4),
        .ext_int(e4), .mtime(mt4), .mtimecmp(mc4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = 0; m_cmp = '1; m_timer = 0; m_soft = 0; m_ext = 0; cyc = 0;
        hist.delete();
    endtask

    // s_out after n accepted edges is the sample taken S edges earlier
    function automatic logic s_after(input int n);
        return (n >= S) ? hist[n-S] : 1'b0;
    endfunction

    task automatic step();
        int n;
        @(posedge clk);
        if (nRST) begin
            n = hist.size();
`ifdef PRIV_EXT_INT_EDGE_EN
            m_ext = (s_after(n) & ~s_after(n-1)) | (m_ext & ~ack);
`endif
            hist.push_back(ext_in);
`ifndef PRIV_EXT_INT_EDGE_EN
            m_ext = s_after(n + 1);
`endif
            m_timer = (wen | clr) ? 1'b0 : ((m_mtime >= m_cmp) ? 1'b1 : m_timer);
            m_mtime = m_mtime + 1;
            if (wen) m_cmp = hi ? {wdata, m_cmp[31:0]} : {m_cmp[63:32], wdata};
            m_soft = sset ? 1'b1 : (sclr ? 1'b0 : m_soft);
            cyc++;
        end
        #1;
        chk("mtime", mt1, m_mtime);
        chk("mtimecmp", mc1, m_cmp);
        chk("timer_int", {63'd0, t1}, {63'd0, m_timer});
        chk("soft_int", {63'd0, s1}, {63'd0, m_soft});
        chk("ext_int", {63'd0, e1}, {63'd0, m_ext});
        chk("mtime_pre4", mt4, 64'(cyc / 4));
    endtask

    initial begin
        int hcnt;
        bit found;
        model_reset();
        repeat (3) step();
        chk("rst_mtimecmp", mc1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_mtime", mt1, 64'd0);
        nRST = 1;
        wen = 1; hi = 0; wdata = 10; step();
        hi = 1; wdata = 0; step();
        wen = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (mt1 == 64'd10) found = 1;
        end
        chk("mtime_reach10", {63'd0, found}, 64'd1);
        chk("timer_before", {63'd0, t1}, 64'd0);
        step();
        chk("timer_rise", {63'd0, t1}, 64'd1);
        clr = 1; step(); clr = 0;
        chk("timer_clr_low", {63'd0, t1}, 64'd0);
        step();
        chk("timer_reassert", {63'd0, t1}, 64'd1);
        wen = 1; hi = 1; wdata = 32'hFFFF_FFFF; step(); wen = 0;
        repeat (3) step();
        chk("timer_hi_write", {63'd0, t1}, 64'd0);
        sset = 1; sclr = 1; step();
        chk("soft_both", {63'd0, s1}, 64'd1);
        sset = 0; step();
        chk("soft_clr", {63'd0, s1}, 64'd0);
        sclr = 0;
`ifdef PRIV_EXT_INT_EDGE_EN
        ext_in = 1;
        repeat (S) step();
        chk("edge_not_yet", {63'd0, e1}, 64'd0);
        step();
        chk("edge_set", {63'd0, e1}, 64'd1);
        ack = 1; step(); ack = 0;
        repeat (4) step();
        chk("edge_ack_held", {63'd0, e1}, 64'd0);
        ext_in = 0; repeat (S + 2) step();
        ext_in = 1; repeat (S) step();
        ack = 1; step(); ack = 0;
        chk("edge_vs_ack", {63'd0, e1}, 64'd1);
        ack = 1; step(); ack = 0; ext_in = 0;
        repeat (S + 2) step();
`else
        hcnt = 0;
        ext_in = 1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) ext_in = 0;
            step();
            if (i == S - 2) chk("level_lat_lo", {63'd0, e1}, 64'd0);
            if (i == S - 1) chk("level_lat_hi", {63'd0, e1}, 64'd1);
            hcnt += int'(e1);
        end
        chk("level_width", 64'(hcnt), 64'd5);
`endif
        for (int i = 0; i < 300; i++) begin
            wen = ($urandom_range(0, 7) == 0);
            hi = ($urandom_range(0, 3) == 0);
            wdata = hi ? 32'd0 : m_mtime[31:0] + $urandom_range(0, 30) - 32'd5;
            clr = ($urandom_range(0, 5) == 0);
            sset = ($urandom_range(0, 3) == 0);
            sclr = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) ext_in = ~ext_in;
            step();
        end
        {wen, hi, clr, sset, sclr, ack} = '0;
        wen = 1; hi = 0; wdata = 32'd5; step();
        hi = 1; wdata = 32'd0; step(); wen = 0;
        force u1.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release u1.mtime_q;
        m_mtime = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("force_max", mt1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("wrap_zero", mt1, 64'd0);
        step();
        chk("timer_after_wrap", {63'd0, t1}, 64'd1);
        ext_in = 0; repeat (S + 2) step();
        ext_in = 1; repeat (S + 2) step();
        #3 nRST = 0;
        #1;
        model_reset();
        chk("arst_ext", {63'd0, e1}, 64'd0);
        chk("arst_timer", {63'd0, t1}, 64'd0);
        chk("arst_mtime", mt1, 64'd0);
        chk("arst_mtimecmp", mc1, 64'hFFFF_FFFF_FFFF_FFFF);
        ext_in = 0;
        step();
        nRST = 1;
        repeat (40) step();
        chk("pre4_40cyc", mt4, 64'd10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
